// File: rtl/uart_rx_shifter.sv
// UART receive shifter: synchronises rxd, validates the start bit on the
// oversampling tick and assembles data, optional parity and stop into frame results.
module uart_rx_shifter #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rxd,
    input  logic [1:0] wls,
    input  logic       pen,
    output logic [7:0] rsr_data,
    output logic       received_parity,
    output logic       rx_done,
    output logic       framing_error,
    output logic       break_detect,
    output logic       rx_busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;
    logic [CW-1:0]          tick_cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;
    logic                   par_q;
    logic                   seen_one;
    logic [1:0]             wls_q;
    logic                   pen_q;
    logic                   armed;
    logic                   last_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
    assign rxd_s = sync_q[SYNC_STAGES-1];

    // Last data index is word length - 1, i.e. wls + 4.
    assign last_bit = (bit_idx == ({1'b0, wls_q} + 3'd4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            tick_cnt        <= '0;
            bit_idx         <= '0;
            shift           <= '0;
            par_q           <= 1'b0;
            seen_one        <= 1'b0;
            wls_q           <= '0;
            pen_q           <= 1'b0;
            armed           <= 1'b1;
            rsr_data        <= '0;
            received_parity <= 1'b0;
            rx_done         <= 1'b0;
            framing_error   <= 1'b0;
            break_detect    <= 1'b0;
            rx_busy         <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (baud_tick) begin
                case (state)
                    IDLE: begin
                        if (rxd_s) armed <= 1'b1;
                        else if (armed) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (tick_cnt == HALF_M1) begin
                            if (rxd_s) state <= IDLE;
                            else begin
                                wls_q    <= wls;
                                pen_q    <= pen;
                                rx_busy  <= 1'b1;
                                shift    <= '0;
                                par_q    <= 1'b0;
                                seen_one <= 1'b0;
                                bit_idx  <= '0;
                                tick_cnt <= '0;
                                state    <= DATA;
                            end
                        end else tick_cnt <= tick_cnt + CW'(1);
                    end
                    DATA: begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt       <= '0;
                            shift[bit_idx] <= rxd_s;
                            seen_one       <= seen_one | rxd_s;
                            bit_idx        <= bit_idx + 3'd1;
                            if (last_bit) state <= pen_q ? PARITY : STOP;
                        end else tick_cnt <= tick_cnt + CW'(1);
                    end
                    PARITY: begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt <= '0;
                            par_q    <= rxd_s;
                            seen_one <= seen_one | rxd_s;
                            state    <= STOP;
                        end else tick_cnt <= tick_cnt + CW'(1);
                    end
                    STOP: begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt        <= '0;
                            rsr_data        <= shift;
                            received_parity <= par_q & pen_q;
                            framing_error   <= ~rxd_s;
                            break_detect    <= ~seen_one & ~rxd_s;
                            rx_done         <= 1'b1;
                            rx_busy         <= 1'b0;
                            // A low stop bit leaves the receiver disarmed until the line idles high.
                            armed           <= rxd_s;
                            state           <= IDLE;
                        end else tick_cnt <= tick_cnt + CW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_shifter.sv
// Scoreboard bench for uart_rx_shifter: frames are generated serially, the
// expected result is queued at issue time and a monitor checks each rx_done.
module tb_uart_rx_shifter;
    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst, baud_tick, rxd, pen;
    logic [1:0] wls;
    logic [7:0] rsr_data;
    logic       received_parity, rx_done, framing_error, break_detect, rx_busy;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       fe;
        logic       brk;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0, ndone = 0, busy_ticks = 0, tcnt = 0;

    uart_rx_shifter #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rxd(rxd), .wls(wls), .pen(pen),
        .rsr_data(rsr_data), .received_parity(received_parity), .rx_done(rx_done),
        .framing_error(framing_error), .break_detect(break_detect), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    // Baud tick every 4 clocks, changed 1 time unit after the rising edge.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt + 1) % 4;
            baud_tick = (tcnt == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every rx_done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (baud_tick && rx_busy) busy_ticks++;
            if (rx_done) begin
                ndone++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rx_done actual=1 required=0 data=%0h", rsr_data);
                end else begin
                    e = q.pop_front();
                    chk("rsr_data", {24'd0, rsr_data}, {24'd0, e.d});
                    chk("received_parity", {31'd0, received_parity}, {31'd0, e.p});
                    chk("framing_error", {31'd0, framing_error}, {31'd0, e.fe});
                    chk("break_detect", {31'd0, break_detect}, {31'd0, e.brk});
                end
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (baud_tick !== 1'b1);
        end
        #2;
    endtask

    function automatic exp_t model(input logic [7:0] d, input int wl, input logic p_en,
                                   input logic pbit, input logic stop);
        exp_t e;
        logic [7:0] mask;
        mask  = 8'((1 << wl) - 1);
        e.d   = d & mask;
        e.p   = p_en ? pbit : 1'b0;
        e.fe  = !stop;
        e.brk = (e.d == 8'd0) && (!p_en || !pbit) && !stop;
        return e;
    endfunction

    // chg: rewrite wls/pen right after the start bit to prove the frame config is latched.
    task automatic send_frame(input logic [7:0] d, input int wl, input logic p_en,
                              input logic pbit, input logic stop, input int gap, input bit chg);
        wls = 2'(wl - 5);
        pen = p_en;
        q.push_back(model(d, wl, p_en, pbit, stop));
        rxd = 1'b0;
        wait_ticks(OS);
        if (chg) begin
            wls = 2'b00;
            pen = ~p_en;
        end
        for (int i = 0; i < wl; i++) begin
            rxd = d[i];
            wait_ticks(OS);
        end
        if (p_en) begin
            rxd = pbit;
            wait_ticks(OS);
        end
        rxd = stop;
        wait_ticks(OS);
        rxd = 1'b1;
        if (gap > 0) wait_ticks(gap);
    endtask

    initial begin
        int n0, wl, gap;
        logic [7:0] d;
        logic p_en, pbit, stop;

        rst = 1'b1; rxd = 1'b1; wls = 2'b11; pen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsr_data", {24'd0, rsr_data}, 32'd0);
        chk("reset_parity", {31'd0, received_parity}, 32'd0);
        chk("reset_rx_done", {31'd0, rx_done}, 32'd0);
        chk("reset_fe", {31'd0, framing_error}, 32'd0);
        chk("reset_brk", {31'd0, break_detect}, 32'd0);
        chk("reset_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        wait_ticks(8);

        // 8N1 0xA5
        n0 = ndone;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 4, 1'b0);
        chk("8n1_done_count", ndone - n0, 32'd1);

        // 5-bit with parity; busy spans (1 + wl + pen) bit periods of ticks
        busy_ticks = 0;
        send_frame(8'h1B, 5, 1'b1, 1'b1, 1'b1, 4, 1'b0);
        chk("busy_ticks_5p", busy_ticks, 32'((1 + 5 + 1) * OS));

        // Glitch low for 4 ticks: false start
        n0 = ndone; busy_ticks = 0;
        rxd = 1'b0; wait_ticks(4);
        rxd = 1'b1; wait_ticks(OS);
        chk("glitch_no_done", ndone - n0, 32'd0);
        chk("glitch_no_busy", busy_ticks, 32'd0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 2, 1'b0);

        // 7E1 with a low stop bit, then a normal frame
        send_frame(8'h55, 7, 1'b1, 1'b0, 1'b0, 3, 1'b0);
        send_frame(8'h2A, 7, 1'b1, 1'b1, 1'b1, 3, 1'b0);

        // Break: line low for three 8-bit+parity frame times
        n0 = ndone;
        wls = 2'b11; pen = 1'b1;
        q.push_back(model(8'h00, 8, 1'b1, 1'b0, 1'b0));
        rxd = 1'b0;
        wait_ticks(3 * 11 * OS);
        rxd = 1'b1;
        wait_ticks(20);
        chk("break_single_done", ndone - n0, 32'd1);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 4, 1'b0);

        // Reset in the middle of a 0xFF frame
        n0 = ndone;
        wls = 2'b11; pen = 1'b0;
        rxd = 1'b0; wait_ticks(OS);
        rxd = 1'b1; wait_ticks(3 * OS);
        rst = 1'b1;
        #1;
        chk("midrst_rsr_data", {24'd0, rsr_data}, 32'd0);
        chk("midrst_busy", {31'd0, rx_busy}, 32'd0);
        chk("midrst_fe", {31'd0, framing_error}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        wait_ticks(8 * OS);
        chk("midrst_no_done", ndone - n0, 32'd0);

        // wls/pen changed after the start bit: frame still 8N1
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 4, 1'b1);

        // Randomized frames, occasionally with a low stop bit or back-to-back
        for (int k = 0; k < 30; k++) begin
            d    = 8'($urandom);
            wl   = 5 + int'($urandom_range(3));
            p_en = 1'($urandom);
            pbit = 1'($urandom);
            stop = ($urandom_range(7) != 0);
            if (($urandom_range(9)) == 0) d = 8'h00;
            gap  = stop ? int'($urandom_range(20)) : 1 + int'($urandom_range(19));
            send_frame(d, wl, p_en, pbit, stop, gap, 1'b0);
        end

        for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
